// File: rtl/seq_pkg.sv
// Shared definitions for the up/down sequence counter slice.
// MODE parameter encodings for boundary behaviour.
package seq_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage : seq_pkg

// File: rtl/updown_seq_fsm_if.sv
// Control/status bundle for updown_seq_fsm; master drives controls, slave is the counter.
interface updown_seq_fsm_if #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
);

    logic             en;
    logic             A;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] state_o;
    logic             Y;
    logic             wrap;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output en, A, load, load_val,
        input  state_o, Y, wrap, hit_cnt
    );

    modport slave (
        input  en, A, load, load_val,
        output state_o, Y, wrap, hit_cnt
    );

endinterface : updown_seq_fsm_if

// File: rtl/updown_seq_fsm_sat_counter.sv
// Saturating event counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/updown_seq_fsm.sv
// Up/down modulo sequence counter with load, wrap/saturate boundary mode,
// Moore terminal flag, Mealy boundary flag and a saturating terminal-entry count.
module updown_seq_fsm
    import seq_pkg::*;
#(
    parameter int WIDTH   = 2,
    parameter int MODULUS = 4,
    parameter int MODE    = 0,
    parameter int CNT_W   = 8
) (
    input logic             clk,
    input logic             rst,
    updown_seq_fsm_if.slave bus
);

    if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
        $error("updown_seq_fsm: MODULUS must lie in 2..2**WIDTH");
    end
    if ((MODE != MODE_WRAP) && (MODE != MODE_SAT)) begin : g_bad_mode
        $error("updown_seq_fsm: MODE must be MODE_WRAP or MODE_SAT");
    end

    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   ONE_EXT = (WIDTH + 1)'(1);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH:0]   up_ext;
    logic [WIDTH:0]   dn_ext;
    logic             at_top;
    logic             at_bot;
    logic             hit_inc;

    // One extra bit: up_ext reaching MODULUS marks the top, dn_ext's MSB marks underflow,
    // which keeps MODULUS == 2**WIDTH exact.
    assign up_ext = {1'b0, state_q} + ONE_EXT;
    assign dn_ext = {1'b0, state_q} - ONE_EXT;
    assign at_top = (up_ext == MOD_EXT);
    assign at_bot = dn_ext[WIDTH];

    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : '0;
        end else if (bus.en) begin
            if (!bus.A) begin
                if (at_top) begin
                    state_d = (MODE == MODE_SAT) ? state_q : '0;
                end else begin
                    state_d = up_ext[WIDTH-1:0];
                end
            end else begin
                if (at_bot) begin
                    state_d = (MODE == MODE_SAT) ? state_q : LAST;
                end else begin
                    state_d = dn_ext[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    assign hit_inc = (state_d == LAST) && !at_top;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_inc),
        .cnt (bus.hit_cnt)
    );

    assign bus.state_o = state_q;
    assign bus.Y       = at_top;
    assign bus.wrap    = !bus.load && bus.en && (bus.A ? at_bot : at_top);

endmodule : updown_seq_fsm
